// File: rtl/daq_rd_sm_pkg.sv
// Platform constants shared by the DAQ file reader and writer: descriptor layout,
// status/control bit positions and the base of the descriptor RAM.
package daq_rd_sm_pkg;

    // Descriptor RAM base; each file owns a 0x20-byte descriptor slot.
    localparam logic [31:0] WB_RAM0          = 32'h0000_1000;
    localparam logic [31:0] FILE_DESC_STRIDE = 32'h0000_0020;

    // Descriptor field byte offsets within a slot.
    localparam logic [31:0] FILE_START_OFFSET   = 32'h00;
    localparam logic [31:0] FILE_END_OFFSET     = 32'h04;
    localparam logic [31:0] FILE_RD_PTR_OFFSET  = 32'h08;
    localparam logic [31:0] FILE_WR_PTR_OFFSET  = 32'h0C;
    localparam logic [31:0] FILE_STATUS_OFFSET  = 32'h10;
    localparam logic [31:0] FILE_CONTROL_OFFSET = 32'h14;

    // STATUS word bit positions.
    localparam int unsigned F_STATUS_EMPTY       = 0;
    localparam int unsigned F_STATUS_FULL        = 1;
    localparam int unsigned F_STATUS_WRAP_AROUND = 2;

    // CONTROL word: 2-bit sample size field starting at this bit.
    localparam int unsigned F_CONTROL_DATA_SIZE = 0;

    localparam logic [1:0] B_CONTROL_DATA_SIZE_UNDEFINED = 2'd0;
    localparam logic [1:0] B_CONTROL_DATA_SIZE_BYTE      = 2'd1;
    localparam logic [1:0] B_CONTROL_DATA_SIZE_HWORD     = 2'd2;
    localparam logic [1:0] B_CONTROL_DATA_SIZE_WORD      = 2'd3;

    // Index of the last descriptor field fetched (CONTROL).
    localparam logic [2:0] DESC_LAST_FIELD = 3'd5;

    // Fetch order of descriptor fields: START, END, RD_PTR, WR_PTR, STATUS, CONTROL.
    function automatic logic [31:0] desc_field_offset(input logic [2:0] idx);
        case (idx)
            3'd0:    return FILE_START_OFFSET;
            3'd1:    return FILE_END_OFFSET;
            3'd2:    return FILE_RD_PTR_OFFSET;
            3'd3:    return FILE_WR_PTR_OFFSET;
            3'd4:    return FILE_STATUS_OFFSET;
            default: return FILE_CONTROL_OFFSET;
        endcase
    endfunction

endpackage

// File: rtl/daq_rd_sm_mem_req.sv
// daq_mem_req: single-transfer handshake toward the shared Wishbone master.
// A go pulse latches the request and raises start; start is held until the
// master reports active, then start/write drop and the transfer completes on
// the first cycle active is low again (done_o pulses, rdata_o valid then).
module daq_mem_req #(
    parameter int unsigned Dw = 32,
    parameter int unsigned Aw = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          go_i,
    input  logic [Aw-1:0] addr_i,
    input  logic [3:0]    sel_i,
    input  logic          we_i,
    input  logic [Dw-1:0] wdata_i,
    output logic          done_o,
    output logic [Dw-1:0] rdata_o,
    output logic [Aw-1:0] address_o,
    output logic          start_o,
    output logic [3:0]    selection_o,
    output logic          write_o,
    output logic [Dw-1:0] data_wr_o,
    input  logic [Dw-1:0] data_rd_i,
    input  logic          active_i
);

    typedef enum logic [1:0] {MIdle, MStart, MBusy} mst_e;

    mst_e          mst_q, mst_d;
    logic [Aw-1:0] addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [Dw-1:0] wdata_q, wdata_d;
    logic          start_q, start_d;

    // Handshake next-state: request latch, start hold, completion detect.
    always_comb begin
        mst_d   = mst_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        start_d = start_q;
        done_o  = 1'b0;
        case (mst_q)
            MIdle: begin
                if (go_i) begin
                    addr_d  = addr_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    start_d = 1'b1;
                    mst_d   = MStart;
                end
            end
            MStart: begin
                if (active_i) begin
                    start_d = 1'b0;
                    we_d    = 1'b0;
                    mst_d   = MBusy;
                end
            end
            MBusy: begin
                if (!active_i) begin
                    // Bus returns to all-zero between transfers.
                    done_o  = 1'b1;
                    addr_d  = '0;
                    sel_d   = '0;
                    wdata_d = '0;
                    mst_d   = MIdle;
                end
            end
            default: begin
                addr_d  = '0;
                sel_d   = '0;
                we_d    = 1'b0;
                wdata_d = '0;
                start_d = 1'b0;
                mst_d   = MIdle;
            end
        endcase
    end

    // Handshake state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mst_q   <= MIdle;
            addr_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            mst_q   <= mst_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
        end
    end

    assign rdata_o     = data_rd_i;
    assign address_o   = addr_q;
    assign start_o     = start_q;
    assign selection_o = sel_q;
    assign write_o     = we_q;
    assign data_wr_o   = wdata_q;

endmodule

// File: rtl/daq_rd_sm.sv
// DAQ file reader: on file_read, fetches a file descriptor, pops one sample at
// RD_PTR, then writes back STATUS and the advanced RD_PTR.
module daq_rd_sm
    import daq_rd_sm_pkg::*;
#(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int DEBUG = 0
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [7:0]    file_num,
    input  logic          file_read,
    output logic [31:0]   file_read_data,
    output logic          file_read_valid,
    output logic          file_read_empty,
    output logic          file_read_error,
    output logic          file_active,
    output logic [aw-1:0] address,
    output logic          start,
    output logic [3:0]    selection,
    output logic          write,
    output logic [dw-1:0] data_wr,
    input  logic [dw-1:0] data_rd,
    input  logic          active
);

    if (DEBUG != 0) begin : g_debug
    end

    typedef enum logic [3:0] {
        StIdle, StDescReq, StDescWait, StCheck, StDataReq, StDataWait,
        StStatusReq, StStatusWait, StRdptrReq, StRdptrWait, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [aw-1:0] base_q, base_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   start_ptr_q, start_ptr_d;
    logic [31:0]   end_ptr_q, end_ptr_d;
    logic [31:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]   status_q, status_d;
    logic [1:0]    size_q, size_d;
    logic          no_pop_q, no_pop_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          empty_q, empty_d;
    logic          error_q, error_d;
    logic          active_q, active_d;

    logic          mem_go, mem_we, mem_done;
    logic [aw-1:0] mem_addr;
    logic [3:0]    mem_sel;
    logic [dw-1:0] mem_wdata, mem_rdata;
    logic [31:0]   rword;

    logic [3:0]    lane_sel;
    logic [31:0]   lane_data, ptr_inc, ptr_sum, ptr_next;
    logic          ptr_wrap;

    assign rword = mem_rdata[31:0];

    // Byte-lane select and right-justified sample for the current size and RD_PTR.
    always_comb begin
        lane_sel  = 4'h0;
        lane_data = 32'h0;
        ptr_inc   = 32'd0;
        case (size_q)
            B_CONTROL_DATA_SIZE_WORD: begin
                lane_sel  = 4'hF;
                lane_data = rword;
                ptr_inc   = 32'd4;
            end
            B_CONTROL_DATA_SIZE_HWORD: begin
                lane_sel  = rd_ptr_q[1] ? 4'hC : 4'h3;
                lane_data = {16'h0, rd_ptr_q[1] ? rword[31:16] : rword[15:0]};
                ptr_inc   = 32'd2;
            end
            B_CONTROL_DATA_SIZE_BYTE: begin
                lane_sel  = 4'b0001 << rd_ptr_q[1:0];
                lane_data = {24'h0, rword[{rd_ptr_q[1:0], 3'b000} +: 8]};
                ptr_inc   = 32'd1;
            end
            default: ;
        endcase
    end

    // Advanced read pointer; stepping past END wraps back to START.
    always_comb begin
        ptr_sum  = rd_ptr_q + ptr_inc;
        ptr_wrap = ptr_sum > end_ptr_q;
        ptr_next = ptr_wrap ? start_ptr_q : ptr_sum;
    end

    // Reader FSM next-state, descriptor capture and memory request decode.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        start_ptr_d = start_ptr_q;
        end_ptr_d   = end_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        status_d    = status_q;
        size_d      = size_q;
        no_pop_d    = no_pop_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        empty_d     = 1'b0;
        error_d     = 1'b0;
        active_d    = active_q;
        mem_go      = 1'b0;
        mem_addr    = '0;
        mem_sel     = 4'h0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        case (state_q)
            StIdle: begin
                if (file_read) begin
                    base_d   = aw'(WB_RAM0 + FILE_DESC_STRIDE * {24'h0, file_num});
                    cnt_d    = 3'd0;
                    no_pop_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = StDescReq;
                end
            end
            StDescReq: begin
                mem_go   = 1'b1;
                mem_addr = base_q + aw'(desc_field_offset(cnt_q));
                mem_sel  = 4'hF;
                state_d  = StDescWait;
            end
            StDescWait: begin
                if (mem_done) begin
                    case (cnt_q)
                        3'd0:    start_ptr_d = rword;
                        3'd1:    end_ptr_d   = rword;
                        3'd2:    rd_ptr_d    = rword;
                        3'd3:    wr_ptr_d    = rword;
                        3'd4:    status_d    = rword;
                        default: size_d      = rword[F_CONTROL_DATA_SIZE +: 2];
                    endcase
                    if (cnt_q == DESC_LAST_FIELD) begin
                        state_d = StCheck;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        state_d = StDescReq;
                    end
                end
            end
            StCheck: begin
                if (size_q == B_CONTROL_DATA_SIZE_UNDEFINED) begin
                    error_d  = 1'b1;
                    active_d = 1'b0;
                    state_d  = StDone;
                end else if (rd_ptr_q == wr_ptr_q && !status_q[F_STATUS_FULL]) begin
                    status_d[F_STATUS_EMPTY] = 1'b1;
                    empty_d  = 1'b1;
                    no_pop_d = 1'b1;
                    state_d  = StStatusReq;
                end else begin
                    state_d = StDataReq;
                end
            end
            StDataReq: begin
                mem_go   = 1'b1;
                mem_addr = aw'({rd_ptr_q[31:2], 2'b00});
                mem_sel  = lane_sel;
                state_d  = StDataWait;
            end
            StDataWait: begin
                if (mem_done) begin
                    data_d   = lane_data;
                    rd_ptr_d = ptr_next;
                    if (ptr_wrap) begin
                        status_d[F_STATUS_WRAP_AROUND] = 1'b1;
                    end
                    status_d[F_STATUS_FULL]  = 1'b0;
                    status_d[F_STATUS_EMPTY] = (ptr_next == wr_ptr_q);
                    valid_d  = 1'b1;
                    state_d  = StStatusReq;
                end
            end
            StStatusReq: begin
                mem_go          = 1'b1;
                mem_addr        = base_q + aw'(FILE_STATUS_OFFSET);
                mem_sel         = 4'hF;
                mem_we          = 1'b1;
                mem_wdata[31:0] = status_q;
                state_d         = StStatusWait;
            end
            StStatusWait: begin
                if (mem_done) begin
                    if (no_pop_q) begin
                        active_d = 1'b0;
                        state_d  = StDone;
                    end else begin
                        state_d = StRdptrReq;
                    end
                end
            end
            StRdptrReq: begin
                mem_go          = 1'b1;
                mem_addr        = base_q + aw'(FILE_RD_PTR_OFFSET);
                mem_sel         = 4'hF;
                mem_we          = 1'b1;
                mem_wdata[31:0] = rd_ptr_q;
                state_d         = StRdptrWait;
            end
            StRdptrWait: begin
                if (mem_done) begin
                    active_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                active_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                active_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // Reader state and latched descriptor registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            cnt_q       <= 3'd0;
            start_ptr_q <= 32'h0;
            end_ptr_q   <= 32'h0;
            rd_ptr_q    <= 32'h0;
            wr_ptr_q    <= 32'h0;
            status_q    <= 32'h0;
            size_q      <= 2'd0;
            no_pop_q    <= 1'b0;
            data_q      <= 32'h0;
            valid_q     <= 1'b0;
            empty_q     <= 1'b0;
            error_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            start_ptr_q <= start_ptr_d;
            end_ptr_q   <= end_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            status_q    <= status_d;
            size_q      <= size_d;
            no_pop_q    <= no_pop_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            empty_q     <= empty_d;
            error_q     <= error_d;
            active_q    <= active_d;
        end
    end

    daq_mem_req #(
        .Dw(dw),
        .Aw(aw)
    ) u_mem_req (
        .clk_i      (wb_clk),
        .rst_ni     (wb_rst_n),
        .go_i       (mem_go),
        .addr_i     (mem_addr),
        .sel_i      (mem_sel),
        .we_i       (mem_we),
        .wdata_i    (mem_wdata),
        .done_o     (mem_done),
        .rdata_o    (mem_rdata),
        .address_o  (address),
        .start_o    (start),
        .selection_o(selection),
        .write_o    (write),
        .data_wr_o  (data_wr),
        .data_rd_i  (data_rd),
        .active_i   (active)
    );

    assign file_read_data  = data_q;
    assign file_read_valid = valid_q;
    assign file_read_empty = empty_q;
    assign file_read_error = error_q;
    assign file_active     = active_q;

endmodule

// File: tb/tb_daq_rd_sm.sv
// Bench for daq_rd_sm: behavioural Wishbone master/memory, table of pop
// scenarios with hand-computed results, plus a mid-transfer reset sequence.
module tb_daq_rd_sm;

    localparam logic [31:0] RAM0  = 32'h0000_1000;
    localparam int          LIMIT = 400;
    localparam logic [1:0]  SZ_U = 2'd0, SZ_B = 2'd1, SZ_H = 2'd2, SZ_W = 2'd3;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [7:0]  file_num;
    logic        file_read;
    logic [31:0] file_read_data;
    logic        file_read_valid, file_read_empty, file_read_error, file_active;
    logic [31:0] address;
    logic        start;
    logic [3:0]  selection;
    logic        write;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        active;

    daq_rd_sm #(.dw(32), .aw(32), .DEBUG(0)) dut (
        .wb_clk         (wb_clk),
        .wb_rst_n       (wb_rst_n),
        .file_num       (file_num),
        .file_read      (file_read),
        .file_read_data (file_read_data),
        .file_read_valid(file_read_valid),
        .file_read_empty(file_read_empty),
        .file_read_error(file_read_error),
        .file_active    (file_active),
        .address        (address),
        .start          (start),
        .selection      (selection),
        .write          (write),
        .data_wr        (data_wr),
        .data_rd        (data_rd),
        .active         (active)
    );

    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [7:0]  fnum;
        logic [1:0]  size;
        logic [31:0] st, en, rd, wr, status, word;
        int          e_valid, e_empty, e_error;
        logic [31:0] e_data;
        logic [3:0]  e_sel;
        logic [31:0] e_status, e_rdptr;
        int          e_nw;
    } vec_t;

    logic [31:0] mem [logic [31:0]];
    txn_t        log_q[$];
    logic        hold_active;
    int          checks = 0;
    int          errors = 0;
    int          tot_valid = 0, tot_empty = 0, tot_error = 0;
    logic [31:0] cap_data = 32'h0;

    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Master model: accept on start, raise active, drop it two cycles later with
    // read data. Data-region reads (below RAM0) can be stalled via hold_active.
    logic        m_busy;
    logic [1:0]  m_cnt;
    logic [31:0] m_addr;
    always @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            active  <= 1'b0;
            data_rd <= 32'h0;
            m_busy  <= 1'b0;
            m_cnt   <= 2'd0;
            m_addr  <= 32'h0;
        end else if (!m_busy) begin
            if (start) begin
                log_q.push_back('{we: write, addr: address, sel: selection, data: data_wr});
                m_addr <= address;
                m_busy <= 1'b1;
                m_cnt  <= 2'd2;
                active <= 1'b1;
            end
        end else if (m_cnt != 2'd0) begin
            if (!(hold_active && m_addr < RAM0)) m_cnt <= m_cnt - 2'd1;
        end else begin
            active  <= 1'b0;
            m_busy  <= 1'b0;
            data_rd <= mrd(m_addr);
        end
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge wb_clk) begin
        if (wb_rst_n) begin
            if (file_read_valid) begin
                tot_valid <= tot_valid + 1;
                cap_data  <= file_read_data;
            end
            if (file_read_empty) tot_empty <= tot_empty + 1;
            if (file_read_error) tot_error <= tot_error + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] fnum, input logic [1:0] size,
                                input logic [31:0] st, en, rd, wr, status, word,
                                input int ev, ee, er, input logic [31:0] ed,
                                input logic [3:0] es, input logic [31:0] est, erp,
                                input int enw);
        vec_t v;
        v.fnum = fnum; v.size = size; v.st = st; v.en = en; v.rd = rd; v.wr = wr;
        v.status = status; v.word = word; v.e_valid = ev; v.e_empty = ee; v.e_error = er;
        v.e_data = ed; v.e_sel = es; v.e_status = est; v.e_rdptr = erp; v.e_nw = enw;
        return v;
    endfunction

    task automatic load_desc(input vec_t v);
        logic [31:0] base;
        base = RAM0 + 32'h20 * {24'h0, v.fnum};
        mem[base]         = v.st;
        mem[base + 32'h4] = v.en;
        mem[base + 32'h8] = v.rd;
        mem[base + 32'hC] = v.wr;
        mem[base + 32'h10] = v.status;
        mem[base + 32'h14] = {30'h0, v.size};
        mem[{v.rd[31:2], 2'b00}] = v.word;
        file_num = v.fnum;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        logic [31:0] base;
        int s_log, s_v, s_e, s_r, n, idx, nt;
        bit ok;
        base = RAM0 + 32'h20 * {24'h0, v.fnum};
        load_desc(v);
        s_log = log_q.size(); s_v = tot_valid; s_e = tot_empty; s_r = tot_error;
        @(negedge wb_clk) file_read = 1'b1;
        @(negedge wb_clk) file_read = 1'b0;
        n = 0;
        while (file_active && n < LIMIT) begin
            @(negedge wb_clk);
            n++;
        end
        chk({tag, " completes"}, 32'(n < LIMIT), 32'd1);
        @(negedge wb_clk);
        chk({tag, " valid pulses"}, 32'(tot_valid - s_v), 32'(v.e_valid));
        chk({tag, " empty pulses"}, 32'(tot_empty - s_e), 32'(v.e_empty));
        chk({tag, " error pulses"}, 32'(tot_error - s_r), 32'(v.e_error));
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idx = s_log + i;
            if (idx >= log_q.size()) ok = 1'b0;
            else if (log_q[idx].we || log_q[idx].addr != base + 32'(4 * i) ||
                     log_q[idx].sel != 4'hF) ok = 1'b0;
        end
        chk({tag, " descriptor reads"}, 32'(ok), 32'd1);
        nt = log_q.size() - s_log;
        chk({tag, " transfer count"}, 32'(nt), 32'(6 + v.e_valid + v.e_nw));
        if (nt == 6 + v.e_valid + v.e_nw) begin
            idx = s_log + 6;
            if (v.e_valid != 0) begin
                chk({tag, " data addr"}, log_q[idx].addr, {v.rd[31:2], 2'b00});
                chk({tag, " data sel"}, 32'(log_q[idx].sel), 32'(v.e_sel));
                chk({tag, " data is read"}, 32'(log_q[idx].we), 32'd0);
                chk({tag, " popped data"}, cap_data, v.e_data);
                chk({tag, " file_read_data"}, file_read_data, v.e_data);
                idx++;
            end
            if (v.e_nw >= 1) begin
                chk({tag, " status addr"}, log_q[idx].addr, base + 32'h10);
                chk({tag, " status we/sel"}, {27'h0, log_q[idx].we, log_q[idx].sel}, 32'h1F);
                chk({tag, " status value"}, log_q[idx].data, v.e_status);
            end
            if (v.e_nw >= 2) begin
                chk({tag, " rdptr addr"}, log_q[idx + 1].addr, base + 32'h8);
                chk({tag, " rdptr we/sel"}, {27'h0, log_q[idx + 1].we, log_q[idx + 1].sel}, 32'h1F);
                chk({tag, " rdptr value"}, log_q[idx + 1].data, v.e_rdptr);
            end
        end
        chk({tag, " idle bus"}, {address[27:0], start, write, file_active, |selection}, 32'h0);
    endtask

    vec_t vecs[10];

    initial begin
        int s_log, n;
        vec_t va;
        // fnum size st en rd wr status word | valid empty error data sel status rdptr nw
        vecs[0] = mk(8'd0, SZ_W, 32'h100, 32'h1FC, 32'h100, 32'h108, 32'h0, 32'hDEADBEEF,
                     1, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0, 32'h104, 2);
        vecs[1] = mk(8'd0, SZ_B, 32'h100, 32'h1FC, 32'h103, 32'h108, 32'h0, 32'hA1B2C3D4,
                     1, 0, 0, 32'h000000A1, 4'h8, 32'h0, 32'h104, 2);
        vecs[2] = mk(8'd0, SZ_W, 32'h100, 32'h1FC, 32'h1FC, 32'h100, 32'h0, 32'h12345678,
                     1, 0, 0, 32'h12345678, 4'hF, 32'h5, 32'h100, 2);
        vecs[3] = mk(8'd0, SZ_W, 32'h100, 32'h1FC, 32'h120, 32'h120, 32'h4, 32'h0BADF00D,
                     0, 1, 0, 32'h0, 4'h0, 32'h5, 32'h0, 1);
        vecs[4] = mk(8'd0, SZ_U, 32'h100, 32'h1FC, 32'h100, 32'h108, 32'h0, 32'h77777777,
                     0, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        vecs[5] = mk(8'd2, SZ_H, 32'h100, 32'h1FC, 32'h102, 32'h108, 32'h0, 32'hCAFEF00D,
                     1, 0, 0, 32'h0000CAFE, 4'hC, 32'h0, 32'h104, 2);
        vecs[6] = mk(8'd0, SZ_H, 32'h100, 32'h1FC, 32'h100, 32'h102, 32'h0, 32'hCAFEF00D,
                     1, 0, 0, 32'h0000F00D, 4'h3, 32'h1, 32'h102, 2);
        vecs[7] = mk(8'd1, SZ_B, 32'h100, 32'h1FC, 32'h101, 32'h108, 32'h0, 32'hA1B2C3D4,
                     1, 0, 0, 32'h000000C3, 4'h2, 32'h0, 32'h102, 2);
        vecs[8] = mk(8'd0, SZ_W, 32'h100, 32'h1FC, 32'h140, 32'h140, 32'h6, 32'h55AA55AA,
                     1, 0, 0, 32'h55AA55AA, 4'hF, 32'h4, 32'h144, 2);
        vecs[9] = mk(8'd0, SZ_B, 32'h100, 32'h1FC, 32'h1FF, 32'h180, 32'h0, 32'h11223344,
                     1, 0, 0, 32'h00000011, 4'h8, 32'h4, 32'h100, 2);

        wb_rst_n = 1'b0;
        file_read = 1'b0;
        file_num = 8'd0;
        hold_active = 1'b0;
        repeat (2) @(negedge wb_clk);
        chk("reset file_read_data", file_read_data, 32'h0);
        chk("reset pulses", {29'h0, file_read_valid, file_read_empty, file_read_error}, 32'h0);
        chk("reset file_active", 32'(file_active), 32'h0);
        chk("reset address", address, 32'h0);
        chk("reset start/write/sel", {26'h0, start, write, selection}, 32'h0);
        chk("reset data_wr", data_wr, 32'h0);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while the data read is stalled with active held high.
        va = vecs[0];
        va.word = 32'hFEEDFACE;
        load_desc(va);
        hold_active = 1'b1;
        s_log = log_q.size();
        @(negedge wb_clk) file_read = 1'b1;
        @(negedge wb_clk) file_read = 1'b0;
        n = 0;
        while (!(log_q.size() >= s_log + 7 && active) && n < LIMIT) begin
            @(negedge wb_clk);
            n++;
        end
        chk("abort reaches data read", 32'(n < LIMIT), 32'd1);
        repeat (2) @(negedge wb_clk);
        #2 wb_rst_n = 1'b0;
        #1;
        chk("abort file_active", 32'(file_active), 32'h0);
        chk("abort file_read_data", file_read_data, 32'h0);
        chk("abort address", address, 32'h0);
        chk("abort start/write/sel", {26'h0, start, write, selection}, 32'h0);
        hold_active = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        n = 0;
        for (int i = s_log; i < log_q.size(); i++) if (log_q[i].we) n++;
        chk("abort no write-back", 32'(n), 32'h0);
        @(negedge wb_clk);
        run_op(va.fnum == 8'd0 ? vecs[0] : va, "after abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
